uparc_fetch: RTL and testbench

- Instruction fetch pipeline stage; upstream producer of the instruction word and PC consumed by the decode stage.
- Issues single-outstanding word reads on the instruction bus and presents the instruction plus its PC to decode.
- Follows sequential, jump-redirect and exception-redirect control from execute/CU, and raises fetch stall while no valid instruction is available.

---
 rtl/uparc_fetch_pkg.sv | 8 +
 rtl/uparc_fetch_buf.sv | 32 +++
 rtl/uparc_fetch.sv | 131 +++++++++++++
 tb/tb_uparc_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uparc_fetch_pkg.sv
// uparc_fetch_pkg: shared fetch-stage constants, state encoding and address helper
package uparc_fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [2:0] {S_RESET, S_REQ, S_VALID, S_DRAIN, S_ERR} fetch_state_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/uparc_fetch_buf.sv
// uparc_fetch_buf: one-entry prefetch buffer (instr, pc, err) with flush
module uparc_fetch_buf
  import uparc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        flush,
  input  logic        load,
  input  logic        pop,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic        d_err,
  output logic        valid,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc,
  output logic        q_err
);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      valid <= 1'b0;
      q_instr <= NOP;
      q_pc <= 32'h0;
      q_err <= 1'b0;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : pop ? 1'b0 : valid;
      if (load) begin
        q_instr <= d_instr;
        q_pc <= d_pc;
        q_err <= d_err;
      end
    end
endmodule

// File: rtl/uparc_fetch.sv
// uparc_fetch: instruction fetch stage, single-outstanding bus reads, jump/exception redirect.
// Define UPARC_FETCH_PREFETCH_EN to add a one-entry sequential prefetch for 1 instr/cycle.
module uparc_fetch
  import uparc_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_exec_stall,
  input  logic        i_mem_stall,
  output logic        o_fetch_stall,
  input  logic        i_jump_valid,
  input  logic [31:0] i_jump_addr,
  input  logic        i_except_start,
  input  logic [31:0] i_except_addr,
  output logic        o_bus_error,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_IAddr,
  output logic        o_IRdC,
  input  logic [31:0] i_IData,
  input  logic        i_IRdy,
  input  logic        i_IErr
);
  fetch_state_t state;
  logic [31:0] npc;
  logic [31:0] tgt;
  logic redirect, consume, resp, ok, err;
  assign redirect = i_except_start || i_jump_valid;
  assign tgt = word_align(i_except_start ? i_except_addr : i_jump_addr);
  assign consume = !i_exec_stall && !i_mem_stall && !o_fetch_stall;
  assign resp = o_IRdC && i_IRdy;
  assign ok = resp && !i_IErr;
  assign err = resp && i_IErr;
`ifdef UPARC_FETCH_PREFETCH_EN
  localparam logic PF = 1'b1;
  logic buf_valid, buf_err, buf_load, buf_pop;
  logic [31:0] buf_instr, buf_pc;
  assign buf_load = state == S_VALID && resp && !redirect && !consume;
  assign buf_pop = state == S_VALID && consume && buf_valid && !redirect;
  uparc_fetch_buf u_buf (
    .clk(clk), .nrst(nrst), .flush(redirect), .load(buf_load), .pop(buf_pop),
    .d_instr(i_IData), .d_pc(npc), .d_err(i_IErr),
    .valid(buf_valid), .q_instr(buf_instr), .q_pc(buf_pc), .q_err(buf_err)
  );
`else
  localparam logic PF = 1'b0;
`endif
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= S_RESET;
      npc <= BOOT_ADDR;
      o_instr <= NOP;
      o_pc <= BOOT_ADDR;
      o_fetch_stall <= 1'b1;
      o_IRdC <= 1'b0;
      o_IAddr <= BOOT_ADDR;
      o_bus_error <= 1'b0;
    end else begin
      o_bus_error <= 1'b0;
      npc <= redirect ? tgt : (ok && state != S_DRAIN) ? npc + 32'd4 : npc;
      case (state)
        S_RESET: begin
          state <= S_REQ;
          o_IRdC <= 1'b1;
          o_IAddr <= redirect ? tgt : npc;
        end
        S_REQ:
          if (redirect) begin
            state <= i_IRdy ? S_REQ : S_DRAIN;
            if (i_IRdy) o_IAddr <= tgt;
          end else if (ok) begin
            state <= S_VALID;
            o_instr <= i_IData;
            o_pc <= npc;
            o_fetch_stall <= 1'b0;
            o_IRdC <= PF;
            o_IAddr <= npc + 32'd4;
          end else if (err) begin
            state <= S_ERR;
            o_bus_error <= 1'b1;
            o_pc <= npc;
            o_IRdC <= 1'b0;
          end
`ifdef UPARC_FETCH_PREFETCH_EN
        S_VALID:
          if (redirect) begin
            state <= (o_IRdC && !i_IRdy) ? S_DRAIN : S_REQ;
            o_fetch_stall <= 1'b1;
            o_IRdC <= 1'b1;
            if (!(o_IRdC && !i_IRdy)) o_IAddr <= tgt;
          end else if (consume && (buf_valid ? buf_err : err)) begin
            state <= S_ERR;
            o_bus_error <= 1'b1;
            o_pc <= buf_valid ? buf_pc : npc;
            o_fetch_stall <= 1'b1;
            o_IRdC <= 1'b0;
          end else if (consume && (buf_valid || ok)) begin
            o_instr <= buf_valid ? buf_instr : i_IData;
            o_pc <= buf_valid ? buf_pc : npc;
            o_IRdC <= 1'b1;
            o_IAddr <= buf_valid ? npc : npc + 32'd4;
          end else if (consume) begin
            state <= S_REQ;
            o_fetch_stall <= 1'b1;
          end else if (resp) o_IRdC <= 1'b0;
`else
        S_VALID:
          if (redirect || consume) begin
            state <= S_REQ;
            o_fetch_stall <= 1'b1;
            o_IRdC <= 1'b1;
            o_IAddr <= redirect ? tgt : npc;
          end
`endif
        S_DRAIN:
          if (i_IRdy) begin
            state <= S_REQ;
            o_IAddr <= redirect ? tgt : npc;
          end
        S_ERR:
          if (redirect) begin
            state <= S_REQ;
            o_IRdC <= 1'b1;
            o_IAddr <= tgt;
          end
        default: state <= S_RESET;
      endcase
    end
endmodule

// File: tb/tb_uparc_fetch.sv
// tb_uparc_fetch: directed stimulus with a bus responder and a next-PC reference model
module tb_uparc_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef UPARC_FETCH_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif
  logic clk = 0, nrst = 0;
  logic i_exec_stall = 0, i_mem_stall = 0, i_jump_valid = 0, i_except_start = 0;
  logic i_IRdy = 0, i_IErr = 0;
  logic [31:0] i_jump_addr = 0, i_except_addr = 0, i_IData = 0;
  logic o_fetch_stall, o_bus_error, o_IRdC;
  logic [31:0] o_instr, o_pc, o_IAddr;

  always #5 clk = ~clk;

  uparc_fetch dut (
    .clk(clk), .nrst(nrst), .i_exec_stall(i_exec_stall), .i_mem_stall(i_mem_stall),
    .o_fetch_stall(o_fetch_stall), .i_jump_valid(i_jump_valid), .i_jump_addr(i_jump_addr),
    .i_except_start(i_except_start), .i_except_addr(i_except_addr), .o_bus_error(o_bus_error),
    .o_instr(o_instr), .o_pc(o_pc), .o_IAddr(o_IAddr), .o_IRdC(o_IRdC),
    .i_IData(i_IData), .i_IRdy(i_IRdy), .i_IErr(i_IErr)
  );

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  int ws = 0, wcnt = 0, cyc = 0, last_cons = -10, consume_gap = 0, n_accept = 0, n_buserr = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF, exp_pc = 0, prev_addr = 0;
  logic prev_req = 0, prev_rdy = 0, prev_wait = 0, redir_last = 0;
  logic [31:0] acc_log[$];
  logic [31:0] cons_log[$];

  // Bus responder (data = addr ^ K), then checks against the next-PC model, then model update
  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      i_IRdy = 0; i_IErr = 0; wcnt = 0;
      prev_req = 0; prev_rdy = 0; prev_wait = 0; redir_last = 0;
      exp_pc = 32'h0;
    end else begin
      wcnt = (o_IRdC && (!prev_req || prev_rdy)) ? 0 : wcnt + 1;
      i_IRdy = o_IRdC && wcnt >= ws;
      i_IErr = i_IRdy && o_IAddr == err_addr;
      i_IData = o_IAddr ^ K;
      if (prev_wait) begin
        chk("req_hold", o_IRdC, 1);
        chk("addr_hold", o_IAddr, prev_addr);
      end
      if (redir_last) chk("redirect_stall", o_fetch_stall, 1);
      if (o_bus_error) begin
        n_buserr++;
        chk("err_pc", o_pc, err_addr);
        chk("err_stall_now", o_fetch_stall, 1);
      end
      if (!o_fetch_stall) begin
        chk("pc", o_pc, exp_pc);
        chk("instr", o_instr, exp_pc ^ K);
      end
      if (i_IRdy) begin
        n_accept++;
        acc_log.push_back(o_IAddr);
      end
      if (!o_fetch_stall && !i_exec_stall && !i_mem_stall) begin
        cons_log.push_back(o_pc);
        consume_gap = cyc - last_cons;
        last_cons = cyc;
        exp_pc += 32'd4;
      end
      if (i_except_start) exp_pc = i_except_addr & ~32'h3;
      else if (i_jump_valid) exp_pc = i_jump_addr & ~32'h3;
      redir_last = i_except_start || i_jump_valid;
      prev_req = o_IRdC; prev_rdy = i_IRdy; prev_wait = o_IRdC && !i_IRdy; prev_addr = o_IAddr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int g, a0, b0, c0;
    logic [31:0] pend_addr, pc_hold;
    nrst = 0;
    tick(3);
    chk("rst_stall", o_fetch_stall, 1);
    chk("rst_rdc", o_IRdC, 0);
    chk("rst_iaddr", o_IAddr, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_berr", o_bus_error, 0);
    nrst = 1;
    g = 0;
    while (cons_log.size() < 3 && g < 100) begin tick(1); g++; end
    chk("run_timeout", cons_log.size() >= 3, 1);
    chk("acc0", acc_log[0], 32'h0);
    chk("acc1", acc_log[1], 32'h4);
    chk("acc2", acc_log[2], 32'h8);
    chk("cons0_instr_pc", cons_log[0], 32'h0);
    chk("cons2_pc", cons_log[2], 32'h8);
    chk("throughput_gap", consume_gap, PF ? 1 : 2);
    g = 0;
    while (o_fetch_stall && g < 50) begin tick(1); g++; end
    chk("valid_timeout", o_fetch_stall, 0);
    i_exec_stall = 1;
    a0 = n_accept;
    pc_hold = o_pc;
    tick(5);
    chk("stall_pc", o_pc, pc_hold);
    chk("stall_instr", o_instr, pc_hold ^ K);
    chk("stall_reqs", n_accept - a0, PF);
    chk("stall_rdc", o_IRdC, 0);
    ws = 4;
    i_exec_stall = 0;
    pend_addr = PF ? 32'h14 : 32'h10;
    g = 0;
    while (!(o_IRdC && o_IAddr == pend_addr) && g < 50) begin tick(1); g++; end
    chk("pend_timeout", o_IRdC && o_IAddr == pend_addr, 1);
    tick(2);
    i_jump_valid = 1; i_jump_addr = 32'h0000_1003;
    tick(1);
    i_jump_valid = 0;
    g = 0;
    while (o_fetch_stall && g < 50) begin tick(1); g++; end
    chk("jump_pc", o_pc, 32'h1000);
    chk("stale_addr", acc_log[$-1], pend_addr);
    chk("jump_addr", acc_log[$], 32'h1000);
    ws = 0;
    err_addr = 32'h40;
    b0 = n_buserr;
    i_jump_valid = 1; i_jump_addr = 32'h40;
    tick(1);
    i_jump_valid = 0;
    g = 0;
    while (!o_bus_error && g < 20) begin tick(1); g++; end
    chk("berr_seen", o_bus_error, 1);
    chk("berr_pc", o_pc, 32'h40);
    a0 = n_accept;
    tick(5);
    chk("berr_once", n_buserr - b0, 1);
    chk("err_rdc", o_IRdC, 0);
    chk("err_stall", o_fetch_stall, 1);
    chk("err_reqs", n_accept - a0, 0);
    i_except_start = 1; i_except_addr = 32'h80;
    i_jump_valid = 1; i_jump_addr = 32'h200;
    tick(1);
    i_except_start = 0; i_jump_valid = 0;
    g = 0;
    while (o_fetch_stall && g < 50) begin tick(1); g++; end
    chk("exc_pc", o_pc, 32'h80);
    chk("exc_addr", acc_log[$], 32'h80);
    i_jump_valid = 1; i_jump_addr = 32'hFFFF_FFFE;
    tick(1);
    i_jump_valid = 0;
    c0 = cons_log.size();
    i_mem_stall = 1;
    tick(2);
    i_mem_stall = 0;
    g = 0;
    while (cons_log.size() < c0 + 2 && g < 50) begin tick(1); g++; end
    chk("wrap_top", cons_log[c0], 32'hFFFF_FFFC);
    chk("wrap_zero", cons_log[c0+1], 32'h0);
    ws = 10;
    g = 0;
    while (!o_IRdC && g < 50) begin tick(1); g++; end
    tick(1);
    nrst = 0;
    #1;
    chk("rst_async_rdc", o_IRdC, 0);
    tick(2);
    chk("rst_iaddr2", o_IAddr, 32'h0);
    chk("rst_stall2", o_fetch_stall, 1);
    ws = 0;
    nrst = 1;
    g = 0;
    while (o_fetch_stall && g < 50) begin tick(1); g++; end
    chk("boot_pc", o_pc, 32'h0);
    chk("boot_addr", acc_log[$], 32'h0);
    tick(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
